// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared crossbar types, no-grant encoding and index width helpers
package xbar_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } return_arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int grant_w(input int slaves);
        return $clog2(slaves) + 1;
    endfunction

    function automatic int no_grant(input int slaves);
        return slaves;
    endfunction

endpackage

// File: rtl/xbar_return_arbiter_if.sv
// rtl/xbar_return_arbiter_if.sv - return-path arbiter request/grant bundle
interface xbar_return_arbiter_if
    import xbar_pkg::*;
#(
    parameter int masters = 2,
    parameter int slaves  = 2
);
    localparam int MW = idx_w(masters);
    localparam int GW = grant_w(slaves);

    logic          slave_fifo_empty  [0:slaves-1];
    logic [MW-1:0] slave_dest_master [0:slaves-1];
    logic          slave_front_last  [0:slaves-1];
    logic          master_fifo_full;
    logic [GW-1:0] grant_slave_number;
    logic          push_to_fifo;
    logic          grant_valid;

    modport slave (
        input  slave_fifo_empty, slave_dest_master, slave_front_last, master_fifo_full,
        output grant_slave_number, push_to_fifo, grant_valid
    );

    modport master (
        output slave_fifo_empty, slave_dest_master, slave_front_last, master_fifo_full,
        input  grant_slave_number, push_to_fifo, grant_valid
    );

endinterface

// File: rtl/xbar_return_arbiter_rr_picker.sv
// rtl/xbar_return_arbiter_rr_picker.sv - first-set search over a request vector from a start index
module rr_picker #(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] start,
    output logic [SW-1:0] winner,
    output logic          hit
);
    logic [SW-1:0] idx;

    // Walk the ring from the far end back so the position nearest start wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = start + SW'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    assign hit = |req;

endmodule

// File: rtl/xbar_return_arbiter.sv
// rtl/xbar_return_arbiter.sv - per-master round-robin return arbiter for R/B channels
// Define XBAR_RETURN_BURST_LOCK_EN to hold the grant until the LAST beat is pushed.
module xbar_return_arbiter
    import xbar_pkg::*;
#(
    parameter int masters            = 2,
    parameter int slaves             = 2,
    parameter int i_am_master_number = 0
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    xbar_return_arbiter_if.slave bus
);
    localparam int SW = idx_w(slaves);
    localparam int GW = grant_w(slaves);
    localparam int MW = idx_w(masters);
    localparam logic [GW-1:0] NO_GRANT = GW'(no_grant(slaves));
    localparam logic [MW-1:0] MY_ID    = MW'(i_am_master_number);
    localparam logic [0:0]    ST_IDLE  = IDLE;
    localparam logic [0:0]    ST_GRANT = GRANT;
`ifdef XBAR_RETURN_BURST_LOCK_EN
    localparam logic LOCK_EN = 1'b1;
`else
    localparam logic LOCK_EN = 1'b0;
`endif

    logic [0:0]        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              beat_seen_q, beat_seen_d;

    logic [slaves-1:0] req;
    logic [slaves-1:0] pick_req;
    logic [SW-1:0]     pick_start;
    logic [SW-1:0]     pick_idx;
    logic              pick_hit;
    logic [SW-1:0]     g_idx;
    logic              g_req;
    logic              g_last;
    logic              push;
    logic              release_grant;

    always_comb begin
        req = '0;
        for (int s = 0; s < slaves; s++) begin
            req[s] = ~bus.slave_fifo_empty[s] & (bus.slave_dest_master[s] == MY_ID);
        end
    end

    assign g_idx         = grant_q[SW-1:0];
    assign g_req         = (state_q == ST_GRANT) & req[g_idx];
    assign g_last        = bus.slave_front_last[g_idx];
    assign push          = g_req & ~bus.master_fifo_full;
    assign release_grant = push & (g_last | ~LOCK_EN);

    // One picker serves both the idle pick and the back-to-back handover,
    // which excludes the slave currently being released.
    always_comb begin
        pick_req   = req;
        pick_start = rr_ptr_q + SW'(1);
        if (state_q == ST_GRANT) begin
            pick_req[g_idx] = 1'b0;
            pick_start      = g_idx + SW'(1);
        end
    end

    rr_picker #(
        .N  (slaves),
        .SW (SW)
    ) u_picker (
        .req    (pick_req),
        .start  (pick_start),
        .winner (pick_idx),
        .hit    (pick_hit)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_seen_d = beat_seen_q;
        case (state_q)
            ST_IDLE: begin
                grant_d = NO_GRANT;
                if (pick_hit) begin
                    state_d     = ST_GRANT;
                    grant_d     = {1'b0, pick_idx};
                    beat_seen_d = 1'b0;
                end
            end
            default: begin
                if (push) begin
                    beat_seen_d = 1'b1;
                end
                if (release_grant) begin
                    rr_ptr_d    = g_idx;
                    beat_seen_d = 1'b0;
                    if (pick_hit) begin
                        grant_d = {1'b0, pick_idx};
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = NO_GRANT;
                    end
                end else if (!g_req && (!beat_seen_q || !LOCK_EN)) begin
                    // Front entry vanished or retargeted before any beat moved.
                    state_d     = ST_IDLE;
                    grant_d     = NO_GRANT;
                    beat_seen_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            grant_q     <= NO_GRANT;
            rr_ptr_q    <= SW'(slaves - 1);
            beat_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_seen_q <= beat_seen_d;
        end
    end

    assign bus.grant_slave_number = grant_q;
    assign bus.push_to_fifo       = push;
    assign bus.grant_valid        = (grant_q != NO_GRANT);

endmodule

// File: tb/tb_xbar_return_arbiter.sv
// tb/tb_xbar_return_arbiter.sv - directed self-checking bench for xbar_return_arbiter
module tb_xbar_return_arbiter;

    typedef struct {
        logic dest;
        logic last;
    } ent_t;

    logic ACLK;
    logic ARESET;
    logic full;
    int   total;
    int   bad;
    ent_t q [2][$];

    xbar_return_arbiter_if #(.masters(2), .slaves(2)) bus ();

    xbar_return_arbiter #(
        .masters            (2),
        .slaves             (2),
        .i_am_master_number (0)
    ) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic apply();
        bus.master_fifo_full = full;
        for (int s = 0; s < 2; s++) begin
            bus.slave_fifo_empty[s]  = (q[s].size() == 0);
            bus.slave_dest_master[s] = (q[s].size() != 0) ? q[s][0].dest : 1'b0;
            bus.slave_front_last[s]  = (q[s].size() != 0) ? q[s][0].last : 1'b0;
        end
    endtask

    task automatic load(input int s, input int n, input logic dest);
        for (int i = 0; i < n; i++) begin
            q[s].push_back('{dest: dest, last: (i == n - 1)});
        end
    endtask

    // One cycle per character: expected grant digit, push bit, full bit.
    task automatic run(input string tag, input string eg, input string ep, input string ef);
        int g;
        for (int i = 0; i < eg.len(); i++) begin
            full = (ef[i] == 8'd49);
            apply();
            @(negedge ACLK);
            chk($sformatf("%s_grant%0d", tag, i), 32'(bus.grant_slave_number), 32'(int'(eg[i]) - 48));
            chk($sformatf("%s_valid%0d", tag, i), 32'(bus.grant_valid), 32'(eg[i] != 8'd50));
            chk($sformatf("%s_push%0d", tag, i), 32'(bus.push_to_fifo), 32'(int'(ep[i]) - 48));
            g = int'(bus.grant_slave_number);
            if (bus.push_to_fifo === 1'b1 && g < 2 && q[g].size() != 0) begin
                void'(q[g].pop_front());
            end
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic chk_drained(input string tag);
        chk({tag, "_q0"}, 32'(q[0].size()), 32'd0);
        chk({tag, "_q1"}, 32'(q[1].size()), 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        full   = 1'b0;
        ARESET = 1'b1;
        apply();
        @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_grant", 32'(bus.grant_slave_number), 32'd2);
        chk("rst_valid", 32'(bus.grant_valid), 32'd0);
        chk("rst_push", 32'(bus.push_to_fifo), 32'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;

`ifdef XBAR_RETURN_BURST_LOCK_EN
        load(1, 4, 1'b0);
        run("single", "211112", "011110", "000000");
        chk_drained("single");

        for (int r = 0; r < 2; r++) begin
            load(0, 2, 1'b0);
            load(1, 2, 1'b0);
            run($sformatf("fair%0d", r), "200112", "011110", "000000");
            chk_drained("fair");
        end

        load(0, 4, 1'b0);
        run("bp", "200000002", "010001110", "001110000");
        chk_drained("bp");
`else
        load(1, 4, 1'b0);
        run("single", "212121212", "010101010", "000000000");
        chk_drained("single");

        load(0, 3, 1'b0);
        load(1, 3, 1'b0);
        run("alt", "20101012", "01111110", "00000000");
        chk_drained("alt");

        load(0, 3, 1'b0);
        run("bp", "2000020202", "0000101010", "0111000000");
        chk_drained("bp");
`endif

        load(0, 2, 1'b1);
        run("wdest", "222", "000", "000");
        q[0].delete();

        load(0, 1, 1'b0);
        run("stale0", "2", "0", "0");
        void'(q[0].pop_front());
        q[0].push_front('{dest: 1'b1, last: 1'b1});
        run("stale1", "02", "00", "00");
        q[0].delete();

        load(0, 1, 1'b0);
        load(1, 1, 1'b0);
        run("rstmid0", "2", "0", "0");
        chk("rstmid_pre_grant", 32'(bus.grant_slave_number), 32'd1);
        #1;
        ARESET = 1'b1;
        #1;
        chk("rstmid_grant", 32'(bus.grant_slave_number), 32'd2);
        chk("rstmid_valid", 32'(bus.grant_valid), 32'd0);
        chk("rstmid_push", 32'(bus.push_to_fifo), 32'd0);
        ARESET = 1'b0;
        run("rstmid1", "2012", "0110", "0000");
        chk_drained("rstmid");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_return_arbiter.md
# xbar_return_arbiter

Per-master return-path arbiter for the crossbar's R and B channels. One instance per master per channel selects which slave-side return FIFO (R or B) may pop into that master's return FIFO. It drives the grant number and push strobe that the slave-side interfaces compare against their own slave number to generate their pop. Arbitration is round-robin, with optional burst locking until the last beat.

## Interface
- `masters`, 2, number of crossbar masters (power of two, ≥2)
- `slaves`, 2, number of crossbar slaves (power of two, ≥2)
- `i_am_master_number`, 0, index of the master this instance serves
- `ACLK` in 1: single clock, rising edge
- `ARESET` in 1: reset, asynchronous, active-high
- `slave_fifo_empty` in 1 ×[0:slaves-1]: empty flag of each slave's return FIFO
- `slave_dest_master` in $clog2(masters) ×[0:slaves-1]: decoded destination master of each FIFO's front entry
- `slave_front_last` in 1 ×[0:slaves-1]: front entry's LAST bit; tie to 1 for B instances
- `master_fifo_full` in 1: this master's return FIFO full
- `grant_slave_number` out $clog2(slaves)+1: granted slave index; value `slaves` means no grant
- `push_to_fifo` out 1: a beat transfers from the granted slave into this master's FIFO this cycle
- `grant_valid` out 1: `grant_slave_number != slaves`

## Operation
- Request: `req[s] = ~slave_fifo_empty[s] & (slave_dest_master[s] == i_am_master_number)`.
- Registered state: `state` {IDLE, GRANT}, `grant` (reset `slaves`), `rr_ptr` (reset `slaves-1`, so slave 0 wins first), `beat_seen` (reset 0).
- IDLE: if any `req`, pick the first set `req` searching from `rr_ptr+1` modulo `slaves`. Load `grant`, go to GRANT, clear `beat_seen`. Otherwise stay in IDLE with `grant=slaves`.
- GRANT: `push_to_fifo = req[grant] & ~master_fifo_full`. A push sets `beat_seen`.
- Release condition: push & (`slave_front_last[grant]`, or lock disabled). On release, set `rr_ptr<=grant`.
- Back-to-back: on release, if some `req[s]` with `s != grant` is set, the next grant is the round-robin winner from `grant+1` in the same cycle, staying in GRANT. Otherwise go to IDLE.
- Stale grant: in GRANT with `~req[grant]` and `~beat_seen`, drop to IDLE (`grant<=slaves`) next cycle. This covers a FIFO that emptied or a front entry that retargeted.
- Mid-burst (`beat_seen`, lock enabled) with `~req[grant]`: hold the grant and keep `push_to_fifo` low. Slaves do not interleave bursts while lock is enabled.
- `master_fifo_full` only gates push. The grant is held, never released on full.

## Timing
- Reset values: `grant_slave_number=slaves`, `grant_valid=0`, `push_to_fifo=0`.
- `grant` is registered. `push_to_fifo` is combinational from `grant` and the current inputs.
- Latency: `req` rises in cycle N, grant appears in N+1, first push in N+1 if not full.
- Throughput: one beat per cycle while the granted FIFO is non-empty and the master FIFO is not full. The switch between slaves costs 0 cycles.
- Simultaneous requests from all slaves: strict rotation. Each slave gets at most one burst (lock) or one beat (no lock) before every other requester is served.
- `ARESET` asserted mid-burst: immediate return to reset values, with no partial-burst memory.

## Configuration
- `XBAR_RETURN_BURST_LOCK_EN` defined: the grant is held until the LAST beat is pushed. This is the mode for R instances.
- Undefined: the grant is released after every pushed beat and `slave_front_last` is ignored, giving per-beat round-robin. This is the mode for B instances and for interleave-tolerant R.
- `beat_seen` stale-drop logic is present in both modes. Without lock, stale-drop happens whenever `~req[grant]`.

## Structure
- Package `xbar_pkg`: `return_arb_state_t` enum {IDLE, GRANT}. It also holds the constant function for the no-grant encoding (`slaves`) and the `$clog2` width helpers shared with the forward arbiters.
- Sub-module `rr_picker`: combinational first-set search over a `slaves`-bit vector from a start index. It outputs the winner index and an any-hit flag. It is reused for the IDLE pick and the back-to-back pick.

## Test plan
- Single request: slave 1 FIFO non-empty, dest=0, instance master 0 → `grant_slave_number=1` the next cycle, `push_to_fifo=1` for each of 4 beats, release on LAST, then `grant=2` (idle).
- Fairness: slaves 0 and 1 both hold 2-beat bursts for master 0 with lock on → order is 0,0,1,1 with no idle cycle between bursts. A repeat run starts at slave 0 again only after slave 1.
- Backpressure: `master_fifo_full=1` for 3 cycles mid-burst → grant held, push low for 3 cycles, resumes with no beat lost.
- Wrong destination: slave 0 front dest=1 at instance 0 → no grant. A grant that goes stale before the first beat drops to 2 the next cycle.
- Lock off: two slaves each with 3-beat data for master 0 → push alternates 0,1,0,1,0,1.
- Async reset asserted mid-burst between clock edges → outputs reach reset values immediately. After release, arbitration restarts from slave 0.
